sram_read_arb: RTL and testbench

Arbiter and burst sequencer sharing the single SRAM read port among 16 read clients. It accepts per-client read requests (start address plus burst length), selects one winner by fixed-priority override or round-robin, and drives one SRAM read beat per accepted cycle, with incrementing addresses, until the burst completes. It sits between the client read-request bus and the memory controller's `read_sram` / address path, replacing direct client-to-SRAM wiring.

---
 rtl/sram_read_arb.sv | 162 ++++++++++++++++
 tb/tb_sram_read_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arb.sv
// Shares the single SRAM read port among NUM_CLIENTS requesters: picks a winner by
// priority override or round-robin, then issues one incrementing-address beat per accepted cycle.
module sram_read_arb #(
  parameter int NUM_CLIENTS = 16,
  parameter int ADDR_W      = 19,
  parameter int LEN_W       = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CLIENTS-1:0]              client_read_req,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  client_read_addr,
  input  logic [NUM_CLIENTS-1:0][LEN_W-1:0]   client_read_len,
  input  logic [4:0]                          client_priority,
  input  logic                                sram_busy,
  output logic [NUM_CLIENTS-1:0]              read_sram,
  output logic [ADDR_W-1:0]                   sram_addr,
  output logic                                sram_rd_valid,
  output logic [NUM_CLIENTS-1:0]              client_grant,
  output logic [NUM_CLIENTS-1:0]              client_done,
  output logic [$clog2(NUM_CLIENTS)-1:0]      cur_client,
  output logic                                arb_busy
);

  // state | meaning
  // IDLE  | no burst in progress; arbitrate among requesters every cycle
  // BURST | granted burst issuing beats; stalls while sram_busy is high
  typedef enum logic {IDLE, BURST} state_t;

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0]   read_q, read_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
  logic [NUM_CLIENTS-1:0]   done_q, done_d;
  logic [IDX_W-1:0]         cur_q, cur_d;
  logic                     busy_q, busy_d;

  logic                     win_valid;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         idx;
  logic                     accept;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Override client wins only if it is actually requesting; otherwise search
  // upward from the last winner, wrapping through the index width.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = '0;
    if (client_priority < 5'(NUM_CLIENTS) &&
        client_read_req[client_priority[IDX_W-1:0]]) begin
      win_valid = 1'b1;
      win_idx   = client_priority[IDX_W-1:0];
    end else begin
      for (int i = 1; i <= NUM_CLIENTS; i++) begin
        idx = rr_q + IDX_W'(i);
        if (!win_valid && client_read_req[idx]) begin
          win_valid = 1'b1;
          win_idx   = idx;
        end
      end
    end
  end

  assign accept = valid_q && !sram_busy;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    grant_d = '0;
    done_d  = '0;
    cur_d   = cur_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          base_d  = client_read_addr[win_idx];
          len_d   = client_read_len[win_idx];
          cnt_d   = '0;
          rr_d    = win_idx;
          grant_d = onehot(win_idx);
          read_d  = onehot(win_idx);
          valid_d = 1'b1;
          addr_d  = client_read_addr[win_idx];
          cur_d   = win_idx;
          busy_d  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          if (cnt_q == len_q) begin
            valid_d = 1'b0;
            read_d  = '0;
            busy_d  = 1'b0;
            done_d  = onehot(cur_q);
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '1;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      read_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
    end
  end

  assign read_sram     = read_q;
  assign sram_addr     = addr_q;
  assign sram_rd_valid = valid_q;
  assign client_grant  = grant_q;
  assign client_done   = done_q;
  assign cur_client    = cur_q;
  assign arb_busy      = busy_q;

endmodule

// File: tb/tb_sram_read_arb.sv
// Bench for sram_read_arb: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a burst-level behavioural model.
module tb_sram_read_arb;
  localparam int NC = 16;
  localparam int AW = 19;
  localparam int LW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NC-1:0]           client_read_req;
  logic [NC-1:0][AW-1:0]   client_read_addr;
  logic [NC-1:0][LW-1:0]   client_read_len;
  logic [4:0]              client_priority;
  logic                    sram_busy;
  logic [NC-1:0]           read_sram;
  logic [AW-1:0]           sram_addr;
  logic                    sram_rd_valid;
  logic [NC-1:0]           client_grant;
  logic [NC-1:0]           client_done;
  logic [3:0]              cur_client;
  logic                    arb_busy;

  always #5 clk = ~clk;

  sram_read_arb #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .client_read_req  (client_read_req),
    .client_read_addr (client_read_addr),
    .client_read_len  (client_read_len),
    .client_priority  (client_priority),
    .sram_busy        (sram_busy),
    .read_sram        (read_sram),
    .sram_addr        (sram_addr),
    .sram_rd_valid    (sram_rd_valid),
    .client_grant     (client_grant),
    .client_done      (client_done),
    .cur_client       (cur_client),
    .arb_busy         (arb_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Winner rule: override if that client requests, else first requester above the last winner.
  function automatic int pick(input logic [NC-1:0] req, input logic [4:0] prio, input int rr);
    if (prio < 5'd16 && req[prio[3:0]]) return int'(prio);
    for (int k = 1; k <= NC; k++) if (req[(rr + k) % NC]) return (rr + k) % NC;
    return -1;
  endfunction

  // Behavioural model: a burst is (owner, base, last beat index, beats issued so far).
  logic [NC-1:0] exp_read, exp_grant, exp_done;
  logic [AW-1:0] exp_addr;
  logic          exp_valid, exp_arb;
  logic [3:0]    exp_cur;
  bit            m_active;
  int            m_owner, m_base, m_beat, m_last, m_rr, m_win;

  always_comb m_win = pick(client_read_req, client_priority, m_rr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_rr <= 15; m_owner <= 0; m_base <= 0; m_beat <= 0; m_last <= 0;
      exp_read <= '0; exp_grant <= '0; exp_done <= '0; exp_addr <= '0;
      exp_valid <= 1'b0; exp_arb <= 1'b0; exp_cur <= '0;
    end else begin
      exp_grant <= '0;
      exp_done  <= '0;
      if (!m_active) begin
        if (m_win >= 0) begin
          m_active  <= 1'b1;
          m_owner   <= m_win;
          m_base    <= int'(client_read_addr[m_win]);
          m_last    <= int'(client_read_len[m_win]);
          m_beat    <= 0;
          m_rr      <= m_win;
          exp_grant <= NC'(1) << m_win;
          exp_read  <= NC'(1) << m_win;
          exp_valid <= 1'b1;
          exp_addr  <= client_read_addr[m_win];
          exp_cur   <= 4'(m_win);
          exp_arb   <= 1'b1;
        end
      end else if (!sram_busy) begin
        if (m_beat == m_last) begin
          m_active  <= 1'b0;
          exp_valid <= 1'b0;
          exp_read  <= '0;
          exp_arb   <= 1'b0;
          exp_done  <= NC'(1) << m_owner;
        end else begin
          m_beat   <= m_beat + 1;
          exp_addr <= AW'((m_base + m_beat + 1) % (1 << AW));
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_read_sram", read_sram, exp_read);
    check("model_sram_addr", sram_addr, exp_addr);
    check("model_rd_valid", sram_rd_valid, exp_valid);
    check("model_grant", client_grant, exp_grant);
    check("model_done", client_done, exp_done);
    check("model_cur_client", cur_client, exp_cur);
    check("model_arb_busy", arb_busy, exp_arb);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_sram"}, read_sram, 0);
    check({tag, "_sram_addr"}, sram_addr, 0);
    check({tag, "_rd_valid"}, sram_rd_valid, 0);
    check({tag, "_grant"}, client_grant, 0);
    check({tag, "_done"}, client_done, 0);
    check({tag, "_cur_client"}, cur_client, 0);
    check({tag, "_arb_busy"}, arb_busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, output int win);
    win = -1;
    for (int c = 0; c < 20 && win < 0; c++) begin
      step();
      @(negedge clk);
      if (|client_grant) win = oh2i(client_grant);
    end
    if (win < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int win, acc, ng, ngr;
    int g_idx[4];
    int g_cyc[4];
    int rr_exp[4];
    logic [AW-1:0] wrap_exp[4];
    rr_exp = '{0, 5, 15, 0};
    wrap_exp = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    client_read_req = '0; client_read_addr = '0; client_read_len = '0;
    client_priority = 5'd16; sram_busy = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check_all_zero("reset");
    step();
    rst_n = 1'b1;

    // single burst: client 3, 0x100, 4 beats
    client_read_addr[3] = 19'h00100; client_read_len[3] = 4'd3; client_read_req[3] = 1'b1;
    step();
    client_read_req[3] = 1'b0;
    @(negedge clk);
    check("single_grant", client_grant, 32'h8);
    check("single_addr0", sram_addr, 32'h100);
    for (int b = 1; b < 4; b++) begin
      step(); @(negedge clk);
      check("single_addr", sram_addr, 32'h100 + b);
      check("single_valid", sram_rd_valid, 1);
    end
    step(); @(negedge clk);
    check("single_done", client_done, 32'h8);
    check("single_idle_valid", sram_rd_valid, 0);
    step();

    // round-robin from reset pointer
    pulse_reset();
    client_read_len = '0;
    client_read_req = 16'h8021;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      step(); @(negedge clk);
      if (|client_grant) begin
        g_idx[ng] = oh2i(client_grant);
        g_cyc[ng] = c;
        ng++;
      end
    end
    check("rr_count", ng, 4);
    for (int i = 0; i < ng; i++) check("rr_order", g_idx[i], rr_exp[i]);
    for (int i = 1; i < ng; i++) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 2);
    client_read_req = '0;
    repeat (4) step();

    // priority override, then removal of override
    client_priority = 5'd9;
    client_read_req = 16'h0204;
    wait_grant("prio9", win);
    check("prio9_winner", win, 9);
    client_priority = 5'd16;
    wait_grant("prio16", win);
    check("prio16_winner", win, 2);
    client_read_req = '0;
    repeat (4) step();

    // back-pressure on second beat
    acc = 0;
    client_read_addr[1] = 19'h02000; client_read_len[1] = 4'd2; client_read_req[1] = 1'b1;
    step();
    client_read_req[1] = 1'b0;
    @(negedge clk);
    check("bp_grant", client_grant, 32'h2);
    check("bp_addr0", sram_addr, 32'h2000);
    if (sram_rd_valid && !sram_busy) acc++;
    for (int s = 0; s < 4; s++) begin
      step();
      sram_busy = (s < 3);
      @(negedge clk);
      check("bp_hold_addr", sram_addr, 32'h2001);
      check("bp_hold_valid", sram_rd_valid, 1);
      if (sram_rd_valid && !sram_busy) acc++;
    end
    step(); @(negedge clk);
    check("bp_addr2", sram_addr, 32'h2002);
    if (sram_rd_valid && !sram_busy) acc++;
    step(); @(negedge clk);
    check("bp_done", client_done, 32'h2);
    check("bp_beats", acc, 3);
    step();

    // address wrap
    client_read_addr[7] = 19'h7FFFE; client_read_len[7] = 4'd3; client_read_req[7] = 1'b1;
    step();
    client_read_req[7] = 1'b0;
    @(negedge clk);
    check("wrap_grant", client_grant, 32'h80);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin step(); @(negedge clk); end
      check("wrap_addr", sram_addr, wrap_exp[b]);
    end
    step(); @(negedge clk);
    check("wrap_done", client_done, 32'h80);
    step();

    // reset during beat 2 of an 8-beat burst
    client_read_addr[4] = 19'h00500; client_read_len[4] = 4'd7; client_read_req[4] = 1'b1;
    step();
    client_read_req[4] = 1'b0;
    @(negedge clk);
    check("rstmid_grant", client_grant, 32'h10);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rstmid");
    step();
    rst_n = 1'b1;
    client_read_len[0] = '0; client_read_len[8] = '0;
    client_read_req = 16'h0101;
    step();
    client_read_req = '0;
    @(negedge clk);
    check("rstmid_regrant", client_grant, 32'h1);
    repeat (4) step();

    // randomized traffic
    ngr = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      client_read_req = NC'($urandom & $urandom & $urandom);
      for (int i = 0; i < NC; i++) begin
        client_read_addr[i] = ($urandom_range(0, 7) == 0) ? AW'(19'h7FFF0 + $urandom_range(0, 15))
                                                          : AW'($urandom);
        client_read_len[i] = LW'($urandom);
      end
      client_priority = 5'($urandom_range(0, 31));
      sram_busy = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (|client_grant) ngr++;
    end
    check("rand_grants_seen", (ngr > 50), 1);
    rst_n = 1'b1;
    client_read_req = '0;
    sram_busy = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
